ex_mem_datapath: RTL and testbench

- Execute/memory slice of the 8-bit, 19-bit-instruction pipelined processor.
- Contains three parts:
  - operand forwarding mux (register file / EX result / MEM writeback);
  - 8-bit ALU with arithmetic, logic and shift/rotate ops, plus registered zero/carry flags;
  - 256x8 data memory.
- Sits between the ID/EX and EX/MEM pipeline registers; pipeline registers are external.

---
 rtl/ex_mem_datapath_pkg.sv | 38 +++
 rtl/ex_mem_datapath_alu_core.sv | 68 ++++++
 rtl/ex_mem_datapath.sv | 75 +++++++
 tb/tb_ex_mem_datapath.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_datapath_pkg.sv
// Shared widths, opcode encodings and forwarding helper for the EX/MEM slice.
package ex_mem_datapath_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);

  localparam logic [2:0] ACODE_ADD  = 3'b000;
  localparam logic [2:0] ACODE_ADDC = 3'b001;
  localparam logic [2:0] ACODE_SUB  = 3'b010;
  localparam logic [2:0] ACODE_SUBC = 3'b011;
  localparam logic [2:0] ACODE_AND  = 3'b100;
  localparam logic [2:0] ACODE_OR   = 3'b101;
  localparam logic [2:0] ACODE_XOR  = 3'b110;
  localparam logic [2:0] ACODE_MASK = 3'b111;

  localparam logic [1:0] SCODE_SHL = 2'b00;
  localparam logic [1:0] SCODE_SHR = 2'b01;
  localparam logic [1:0] SCODE_ROL = 2'b10;
  localparam logic [1:0] SCODE_ROR = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef logic [DATA_W-1:0] word_t;

  // Select 11 falls back to the register file, same as 00.
  function automatic word_t fwd_mux(input logic [1:0] sel, input word_t reg_data,
                                    input word_t ex_data, input word_t wb_data);
    case (sel)
      FWD_EX:  return ex_data;
      FWD_WB:  return wb_data;
      default: return reg_data;
    endcase
  endfunction

endpackage

// File: rtl/ex_mem_datapath_alu_core.sv
// Combinational 8-bit ALU: add/sub with carry-in, logic ops, shifts and rotates.
module ex_mem_datapath_alu_core
  import ex_mem_datapath_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  input  logic              is_shift,
  input  logic [1:0]        scode,
  input  logic [2:0]        acode,
  output logic [DATA_W-1:0] result_c,
  output logic              zero_c,
  output logic              carry_c
);

  localparam int unsigned EXT_W = DATA_W + 1;

  logic [DATA_W:0]     arith;
  logic [2*DATA_W-1:0] ext;
  logic [2:0]          amt;

  // Shifts run in a double-width word so the bit shifted out is the carry.
  always_comb begin
    arith    = '0;
    ext      = '0;
    amt      = b[2:0];
    result_c = '0;
    carry_c  = 1'b0;
    if (is_shift) begin
      case (scode)
        SCODE_SHL: begin
          ext      = {{DATA_W{1'b0}}, a} << amt;
          result_c = ext[DATA_W-1:0];
          carry_c  = ext[DATA_W];
        end
        SCODE_SHR: begin
          ext      = {a, {DATA_W{1'b0}}} >> amt;
          result_c = ext[2*DATA_W-1:DATA_W];
          carry_c  = ext[DATA_W-1];
        end
        SCODE_ROL: begin
          ext      = {a, a} << amt;
          result_c = ext[2*DATA_W-1:DATA_W];
        end
        default: begin
          ext      = {a, a} >> amt;
          result_c = ext[DATA_W-1:0];
        end
      endcase
    end else begin
      case (acode)
        ACODE_ADD:  arith = {1'b0, a} + {1'b0, b};
        ACODE_ADDC: arith = {1'b0, a} + {1'b0, b} + EXT_W'(c_in);
        // Top bit of the 9-bit difference is the borrow.
        ACODE_SUB:  arith = {1'b0, a} - {1'b0, b};
        ACODE_SUBC: arith = {1'b0, a} - {1'b0, b} - EXT_W'(c_in);
        ACODE_AND:  arith = {1'b0, a & b};
        ACODE_OR:   arith = {1'b0, a | b};
        ACODE_XOR:  arith = {1'b0, a ^ b};
        default:    arith = {1'b0, a & ~b};
      endcase
      result_c = arith[DATA_W-1:0];
      carry_c  = arith[DATA_W];
    end
    zero_c = (result_c == '0);
  end

endmodule

// File: rtl/ex_mem_datapath.sv
// EX/MEM slice: operand forwarding, ALU with Z/C flag registers, 256x8 data memory.
module ex_mem_datapath
  import ex_mem_datapath_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [DATA_W-1:0] reg_data_a,
  input  logic [DATA_W-1:0] reg_data_b,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src,
  input  logic              is_shift,
  input  logic [1:0]        scode,
  input  logic [2:0]        acode,
  input  logic              update_z_c,
  output logic [DATA_W-1:0] alu_result,
  output logic              alu_zero,
  output logic              alu_carry,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic [DATA_W-1:0] fwd_b_data,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_write,
  output logic [DATA_W-1:0] mem_rdata
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  assign op_a       = fwd_mux(fwd_a, reg_data_a, ex_result, wb_result);
  assign fwd_b_data = fwd_mux(fwd_b, reg_data_b, ex_result, wb_result);
  assign op_b       = alu_src ? imm : fwd_b_data;

  ex_mem_datapath_alu_core u_alu_core (
    .a        (op_a),
    .b        (op_b),
    .c_in     (carry_flag),
    .is_shift (is_shift),
    .scode    (scode),
    .acode    (acode),
    .result_c (alu_result),
    .zero_c   (alu_zero),
    .carry_c  (alu_carry)
  );

  // Flags only move when the instruction asks for it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (update_z_c) begin
      zero_flag  <= alu_zero;
      carry_flag <= alu_carry;
    end
  end

  // Reset wipes the whole array and overrides any write on that edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

endmodule

// File: tb/tb_ex_mem_datapath.sv
// Directed-vector bench for ex_mem_datapath with hand-computed expectations.
module tb_ex_mem_datapath;
  import ex_mem_datapath_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] fwd_a, fwd_b;
  logic [7:0] reg_data_a, reg_data_b, ex_result, wb_result, imm;
  logic       alu_src, is_shift, update_z_c;
  logic [1:0] scode;
  logic [2:0] acode;
  logic [7:0] alu_result;
  logic       alu_zero, alu_carry, zero_flag, carry_flag;
  logic [7:0] fwd_b_data;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_write;

  int errors = 0;
  int checks = 0;

  ex_mem_datapath dut (
    .clk        (clk),
    .rst        (rst),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .reg_data_a (reg_data_a),
    .reg_data_b (reg_data_b),
    .ex_result  (ex_result),
    .wb_result  (wb_result),
    .imm        (imm),
    .alu_src    (alu_src),
    .is_shift   (is_shift),
    .scode      (scode),
    .acode      (acode),
    .update_z_c (update_z_c),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .fwd_b_data (fwd_b_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Advance one edge and let outputs settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arith(input logic [2:0] ac, input logic [7:0] a, input logic [7:0] b);
    is_shift   = 1'b0;
    acode      = ac;
    reg_data_a = a;
    reg_data_b = b;
    #1;
  endtask

  task automatic shift(input logic [1:0] sc, input logic [7:0] a, input logic [7:0] n);
    is_shift   = 1'b1;
    scode      = sc;
    reg_data_a = a;
    reg_data_b = n;
    #1;
  endtask

  logic [7:0] fwd_exp [4];
  logic [7:0] logic_exp [4];

  initial begin
    fwd_exp   = '{8'h11, 8'h22, 8'h33, 8'h11};
    logic_exp = '{8'h88, 8'hEE, 8'h66, 8'h44};
    rst = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
    reg_data_a = 8'h00; reg_data_b = 8'h00; ex_result = 8'h00; wb_result = 8'h00;
    imm = 8'h00; alu_src = 1'b0; is_shift = 1'b0; scode = 2'b00; acode = ACODE_ADD;
    update_z_c = 1'b0; mem_addr = 8'h10; mem_wdata = 8'h00; mem_write = 1'b0;

    step();
    rst = 1'b1;
    #1;
    chk("reset_zero_flag", 8'(zero_flag), 8'h00);
    chk("reset_carry_flag", 8'(carry_flag), 8'h00);
    chk("reset_mem", mem_rdata, 8'h00);

    // Forwarding
    ex_result = 8'h22; wb_result = 8'h33;
    for (int i = 0; i < 4; i++) begin
      fwd_a = 2'(i);
      arith(ACODE_ADD, 8'h11, 8'h00);
      chk($sformatf("fwd_a_%0d", i), alu_result, fwd_exp[i]);
    end
    fwd_a = 2'b00;
    for (int i = 0; i < 4; i++) begin
      fwd_b = 2'(i);
      reg_data_b = 8'h44;
      #1;
      chk($sformatf("fwd_b_%0d", i), fwd_b_data, (i == 0 || i == 3) ? 8'h44 : fwd_exp[i]);
    end
    fwd_b = 2'b00;

    // Arithmetic and flag latching
    arith(ACODE_ADD, 8'hF0, 8'h20);
    chk("add_result", alu_result, 8'h10);
    chk("add_carry", 8'(alu_carry), 8'h01);
    chk("add_zero", 8'(alu_zero), 8'h00);
    update_z_c = 1'b1;
    step();
    update_z_c = 1'b0;
    chk("add_carry_flag", 8'(carry_flag), 8'h01);
    chk("add_zero_flag", 8'(zero_flag), 8'h00);
    arith(ACODE_ADDC, 8'h01, 8'h01);
    chk("addc_result", alu_result, 8'h03);
    chk("addc_carry", 8'(alu_carry), 8'h00);
    arith(ACODE_SUBC, 8'h05, 8'h04);
    chk("subc_zero_result", alu_result, 8'h00);
    chk("subc_zero_z", 8'(alu_zero), 8'h01);
    chk("subc_zero_c", 8'(alu_carry), 8'h00);
    arith(ACODE_SUBC, 8'h04, 8'h04);
    chk("subc_borrow_result", alu_result, 8'hFF);
    chk("subc_borrow_c", 8'(alu_carry), 8'h01);
    arith(ACODE_ADDC, 8'hFF, 8'h00);
    chk("addc_wrap_result", alu_result, 8'h00);
    chk("addc_wrap_c", 8'(alu_carry), 8'h01);

    arith(ACODE_SUB, 8'h05, 8'h05);
    chk("sub_eq_result", alu_result, 8'h00);
    chk("sub_eq_zero", 8'(alu_zero), 8'h01);
    chk("sub_eq_carry", 8'(alu_carry), 8'h00);
    update_z_c = 1'b1;
    step();
    update_z_c = 1'b0;
    chk("sub_eq_zero_flag", 8'(zero_flag), 8'h01);
    chk("sub_eq_carry_flag", 8'(carry_flag), 8'h00);

    arith(ACODE_SUB, 8'h03, 8'h05);
    chk("sub_lt_result", alu_result, 8'hFE);
    chk("sub_lt_carry", 8'(alu_carry), 8'h01);
    step();
    chk("hold_zero_flag", 8'(zero_flag), 8'h01);
    chk("hold_carry_flag", 8'(carry_flag), 8'h00);

    // Shifts and rotates on 0x81
    shift(SCODE_SHL, 8'h81, 8'h01);
    chk("shl1_result", alu_result, 8'h02);
    chk("shl1_carry", 8'(alu_carry), 8'h01);
    shift(SCODE_SHR, 8'h81, 8'h01);
    chk("shr1_result", alu_result, 8'h40);
    chk("shr1_carry", 8'(alu_carry), 8'h01);
    shift(SCODE_ROL, 8'h81, 8'h01);
    chk("rol1_result", alu_result, 8'h03);
    chk("rol1_carry", 8'(alu_carry), 8'h00);
    shift(SCODE_ROR, 8'h81, 8'h04);
    chk("ror4_result", alu_result, 8'h18);
    shift(SCODE_SHL, 8'h81, 8'h00);
    chk("shl0_result", alu_result, 8'h81);
    chk("shl0_carry", 8'(alu_carry), 8'h00);
    shift(SCODE_SHR, 8'h81, 8'h00);
    chk("shr0_carry", 8'(alu_carry), 8'h00);
    shift(SCODE_SHR, 8'h81, 8'h09);
    chk("shr_amt_low3", alu_result, 8'h40);
    shift(SCODE_SHL, 8'h81, 8'h07);
    chk("shl7_result", alu_result, 8'h80);
    chk("shl7_carry", 8'(alu_carry), 8'h00);
    shift(SCODE_SHL, 8'h42, 8'h07);
    chk("shl7_carry_set", 8'(alu_carry), 8'h01);

    // Logic ops with immediate B
    alu_src = 1'b1;
    imm = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      arith(3'(4 + i), 8'hCC, 8'h00);
      chk($sformatf("logic_%0d", i), alu_result, logic_exp[i]);
      chk($sformatf("logic_c_%0d", i), 8'(alu_carry), 8'h00);
    end
    alu_src = 1'b0;

    // Memory: old data visible until the write edge
    mem_addr = 8'h10; mem_wdata = 8'h5A; mem_write = 1'b1;
    #1;
    chk("mem_read_before_write", mem_rdata, 8'h00);
    step();
    mem_write = 1'b0;
    chk("mem_read_after_write", mem_rdata, 8'h5A);
    mem_addr = 8'h11;
    #1;
    chk("mem_neighbour", mem_rdata, 8'h00);

    // Set carry so the reset clearing is observable
    arith(ACODE_ADD, 8'hF0, 8'h20);
    update_z_c = 1'b1;
    step();
    chk("pre_reset_carry_flag", 8'(carry_flag), 8'h01);

    // Reset overrides both a flag update and a pending write
    rst = 1'b0;
    mem_addr = 8'h20; mem_wdata = 8'h77; mem_write = 1'b1;
    #1;
    chk("alu_during_reset", alu_result, 8'h10);
    step();
    rst = 1'b1; mem_write = 1'b0; update_z_c = 1'b0;
    #1;
    chk("rst_zero_flag", 8'(zero_flag), 8'h00);
    chk("rst_carry_flag", 8'(carry_flag), 8'h00);
    chk("rst_write_ignored", mem_rdata, 8'h00);
    mem_addr = 8'h10;
    #1;
    chk("rst_mem_cleared", mem_rdata, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
